// File: rtl/z3_slave_ctrl_pkg.sv
// Shared definitions for the Zorro III slave cycle controller.
package z3_slave_ctrl_pkg;

  // FSM state encodings (3-bit, legacy-compatible values)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  // A[31:16] of the Zorro III autoconfig space
  localparam logic [15:0] AC_BASE_DEFAULT = 16'hFF00;

  // Autoconfig register offsets as seen on ADDRL
  localparam logic [5:0] EC_BASEADDR = 6'h11;
  localparam logic [5:0] EC_SHUTUP   = 6'h13;

  // Which target a decoded cycle belongs to
  typedef enum logic {
    TGT_AC   = 1'b0,
    TGT_SCSI = 1'b1
  } tgt_e;

  // 16-bit counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/z3_slave_ctrl_if.sv
// Zorro III bus-side signals seen by the slave controller.
interface z3_slave_ctrl_if;
  import z3_slave_ctrl_pkg::*;

  logic        FCS_n;
  logic [3:0]  DS_n;
  logic [29:0] A;
  logic        READ;
  logic        CFGIN_n;
  logic        SLAVE_n;
  logic        DTACK_n;

  modport master (
    output FCS_n, DS_n, A, READ, CFGIN_n,
    input  SLAVE_n, DTACK_n
  );

  modport slave (
    input  FCS_n, DS_n, A, READ, CFGIN_n,
    output SLAVE_n, DTACK_n
  );
endinterface

// File: rtl/z3_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high bus control line.
module z3_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  import z3_slave_ctrl_pkg::*;

  logic [STAGES-1:0] ff;

  // Shift chain; resets to the idle (high) level so no false edge is seen after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle controller: decodes autoconfig / SCSI register cycles,
// strobes the selected target and turns its ack into DTACK_n/SLAVE_n.
module z3_slave_ctrl
  import z3_slave_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] AC_BASE        = AC_BASE_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  z3_slave_ctrl_if.slave       bus,
  input  logic                 configured,
  input  logic                 shutup,
  input  logic [7:0]           scsi_base_addr,
  input  logic                 ac_dtack,
  input  logic                 scsi_dtack,
  output logic                 autoconfig_cycle,
  output logic                 scsi_cycle,
  output logic [6:0]           ADDRL,
  output logic                 timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        fcs_s;
  logic        ds_any_s;
  logic        fcs_prev;
  logic        fcs_fall;
  logic        ac_hit;
  logic        scsi_hit;
  logic        sel_ack;
  logic [2:0]  state;
  tgt_e        sel;
  logic [15:0] cnt;
  logic        slave_q;
  logic        dtack_q;

  z3_sync #(.STAGES(SYNC_STAGES)) u_sync_fcs (
    .clk   (CLK),
    .rst_n (RESET_n),
    .d     (bus.FCS_n),
    .q     (fcs_s)
  );

  // ds_any_s is high only while every data strobe is released
  z3_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk   (CLK),
    .rst_n (RESET_n),
    .d     (&bus.DS_n),
    .q     (ds_any_s)
  );

  assign fcs_fall = fcs_prev && !fcs_s;

  // Address decode on A[31:2]; bit 29 of A is address bit 31
  assign ac_hit   = (bus.A[29:14] == AC_BASE) && !bus.CFGIN_n && !configured && !shutup;
  assign scsi_hit = configured && (bus.A[29:22] == scsi_base_addr);

  // Only the target latched at decode may complete the cycle
  assign sel_ack = (sel == TGT_AC) ? ac_dtack : scsi_dtack;

  assign bus.SLAVE_n = slave_q;
  assign bus.DTACK_n = dtack_q;

  // Cycle FSM with all bus and target outputs registered
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state            <= ST_IDLE;
      sel              <= TGT_AC;
      cnt              <= '0;
      fcs_prev         <= 1'b1;
      ADDRL            <= '0;
      slave_q          <= 1'b1;
      dtack_q          <= 1'b1;
      autoconfig_cycle <= 1'b0;
      scsi_cycle       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      fcs_prev    <= fcs_s;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fcs_fall) begin
            if (ac_hit || scsi_hit) begin
              ADDRL   <= {bus.A[6], bus.A[5:0]};
              sel     <= ac_hit ? TGT_AC : TGT_SCSI;
              slave_q <= 1'b0;
              state   <= ST_ADDR;
            end else begin
              state   <= ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (fcs_s) begin
            slave_q <= 1'b1;
            state   <= ST_IDLE;
          end else if (!ds_any_s) begin
            autoconfig_cycle <= (sel == TGT_AC);
            scsi_cycle       <= (sel == TGT_SCSI);
            cnt              <= '0;
            state            <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (fcs_s) begin
            autoconfig_cycle <= 1'b0;
            scsi_cycle       <= 1'b0;
            slave_q          <= 1'b1;
            state            <= ST_IDLE;
          end else if (sel_ack) begin
            autoconfig_cycle <= 1'b0;
            scsi_cycle       <= 1'b0;
            dtack_q          <= 1'b0;
            state            <= ST_ACK;
          end else if (cnt == TO_LAST) begin
            autoconfig_cycle <= 1'b0;
            scsi_cycle       <= 1'b0;
            slave_q          <= 1'b1;
            timeout_err      <= 1'b1;
            state            <= ST_IGNORE;
          end else begin
            cnt <= sat_inc16(cnt);
          end
        end
        ST_ACK: begin
          if (fcs_s) begin
            dtack_q <= 1'b1;
            slave_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_IGNORE: begin
          if (fcs_s) state <= ST_IDLE;
        end
        default: begin
          autoconfig_cycle <= 1'b0;
          scsi_cycle       <= 1'b0;
          slave_q          <= 1'b1;
          dtack_q          <= 1'b1;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Directed bench for z3_slave_ctrl with a per-cycle expectation scoreboard.
module tb_z3_slave_ctrl;
  import z3_slave_ctrl_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       configured, shutup, ac_dtack, scsi_dtack;
  logic [7:0] scsi_base_addr;
  logic       autoconfig_cycle, scsi_cycle, timeout_err;
  logic [6:0] ADDRL;

  z3_slave_ctrl_if bus_if();

  z3_slave_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .AC_BASE(16'hFF00)) dut (
    .CLK              (CLK),
    .RESET_n          (RESET_n),
    .bus              (bus_if),
    .configured       (configured),
    .shutup           (shutup),
    .scsi_base_addr   (scsi_base_addr),
    .ac_dtack         (ac_dtack),
    .scsi_dtack       (scsi_dtack),
    .autoconfig_cycle (autoconfig_cycle),
    .scsi_cycle       (scsi_cycle),
    .ADDRL            (ADDRL),
    .timeout_err      (timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         lat;
    logic       ac;
    logic       scsi;
    logic       dtack;
    int         to_cnt;
    int         slen;
    logic [6:0] addrl;
    logic       idle_end;
    logic       done;
  } res_t;

  res_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [6:0] model_addrl = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: what one bus cycle should produce
  task automatic push_expect(input logic [31:0] addr, input bit drv_ac, input bit drv_scsi,
                             input int ack_delay, input int abort_after);
    res_t e;
    bit ac_h, scsi_h, hit, acked;
    ac_h   = (addr[31:16] == 16'hFF00) && !bus_if.CFGIN_n && !configured && !shutup;
    scsi_h = configured && (addr[31:24] == scsi_base_addr);
    hit    = ac_h || scsi_h;
    acked  = hit && ack_delay >= 0 && abort_after < 0 && (ac_h ? drv_ac : drv_scsi);
    e.lat    = hit ? SYNC + 1 : -1;
    e.ac     = hit && ac_h;
    e.scsi   = hit && !ac_h;
    e.dtack  = acked;
    e.to_cnt = (hit && !acked && abort_after < 0) ? 1 : 0;
    // after an abort the strobe stays up while the release crosses the synchroniser
    e.slen   = !hit ? 0 : (abort_after >= 0) ? abort_after + SYNC : acked ? ack_delay : TMO;
    if (hit) model_addrl = {addr[8], addr[7:2]};
    e.addrl    = model_addrl;
    e.idle_end = 1'b1;
    e.done     = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic release_bus();
    bus_if.FCS_n = 1'b1;
    bus_if.DS_n  = 4'hF;
    ac_dtack     = 1'b0;
    scsi_dtack   = 1'b0;
  endtask

  // Drive one host cycle, observe the DUT, then pop and compare the expectation
  task automatic run_cycle(input string name, input logic [31:0] addr, input bit drv_ac,
                           input bit drv_scsi, input int ack_delay, input int abort_after);
    res_t o, e;
    bit   released;
    int   rel_cyc, cyc;
    push_expect(addr, drv_ac, drv_scsi, ack_delay, abort_after);
    o = '{lat: -1, ac: 1'b0, scsi: 1'b0, dtack: 1'b0, to_cnt: 0, slen: 0,
          addrl: 7'd0, idle_end: 1'b0, done: 1'b0};
    released = 1'b0;
    rel_cyc  = 0;
    cyc      = 0;
    @(negedge CLK);
    bus_if.A     = addr[31:2];
    bus_if.READ  = 1'b1;
    bus_if.FCS_n = 1'b0;
    bus_if.DS_n  = 4'h0;
    while (cyc < 400 && !(released && cyc > rel_cyc + 6)) begin
      @(negedge CLK);
      cyc++;
      if (!bus_if.SLAVE_n && o.lat < 0 && !released) o.lat = cyc;
      if (autoconfig_cycle) o.ac = 1'b1;
      if (scsi_cycle) o.scsi = 1'b1;
      if (autoconfig_cycle || scsi_cycle) o.slen++;
      if (timeout_err) o.to_cnt++;
      if (!bus_if.DTACK_n) o.dtack = 1'b1;
      if (!released) begin
        if ((autoconfig_cycle || scsi_cycle) && abort_after >= 0 && o.slen == abort_after) begin
          release_bus(); released = 1'b1; rel_cyc = cyc;
        end else if (!bus_if.DTACK_n || (o.to_cnt > 0 && bus_if.SLAVE_n) ||
                     (o.lat < 0 && cyc >= 8)) begin
          release_bus(); released = 1'b1; rel_cyc = cyc;
        end else if ((autoconfig_cycle || scsi_cycle) && ack_delay >= 0 && o.slen >= ack_delay) begin
          ac_dtack   = drv_ac;
          scsi_dtack = drv_scsi;
        end
      end
    end
    if (!released) release_bus();
    o.done     = released;
    o.addrl    = ADDRL;
    o.idle_end = bus_if.SLAVE_n && bus_if.DTACK_n && !autoconfig_cycle && !scsi_cycle;
    e = exp_q.pop_front();
    chk({name, ".done"},     32'(o.done),     32'(e.done));
    chk({name, ".slave_lat"}, o.lat,           e.lat);
    chk({name, ".ac_strobe"}, 32'(o.ac),       32'(e.ac));
    chk({name, ".scsi_strb"}, 32'(o.scsi),     32'(e.scsi));
    chk({name, ".strobe_len"}, o.slen,         e.slen);
    chk({name, ".dtack"},     32'(o.dtack),    32'(e.dtack));
    chk({name, ".timeouts"},  o.to_cnt,        e.to_cnt);
    chk({name, ".addrl"},     32'(o.addrl),    32'(e.addrl));
    chk({name, ".idle_end"},  32'(o.idle_end), 32'(e.idle_end));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".SLAVE_n"}, 32'(bus_if.SLAVE_n),   32'd1);
    chk({name, ".DTACK_n"}, 32'(bus_if.DTACK_n),   32'd1);
    chk({name, ".ac_cyc"},  32'(autoconfig_cycle), 32'd0);
    chk({name, ".scsi_cyc"}, 32'(scsi_cycle),      32'd0);
    chk({name, ".ADDRL"},   32'(ADDRL),            32'd0);
    chk({name, ".tmo_err"}, 32'(timeout_err),      32'd0);
  endtask

  initial begin
    int n;
    bus_if.FCS_n   = 1'b1;
    bus_if.DS_n    = 4'hF;
    bus_if.A       = '0;
    bus_if.READ    = 1'b0;
    bus_if.CFGIN_n = 1'b0;
    configured     = 1'b0;
    shutup         = 1'b0;
    scsi_base_addr = 8'h00;
    ac_dtack       = 1'b0;
    scsi_dtack     = 1'b0;
    RESET_n        = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET_n = 1'b1;
    repeat (3) @(negedge CLK);

    run_cycle("ac_read",  32'hFF00_0000, 1'b1, 1'b0, 1, -1);
    run_cycle("ac_wbase", 32'hFF00_0044, 1'b1, 1'b0, 1, -1);

    configured     = 1'b1;
    scsi_base_addr = 8'h40;
    run_cycle("scsi_rd",    32'h4000_1000, 1'b0, 1'b1, 2, -1);
    run_cycle("ac_when_cfg", 32'hFF00_0000, 1'b1, 1'b0, 1, -1);
    run_cycle("scsi_both",  32'h4000_01FC, 1'b1, 1'b1, 3, -1);
    run_cycle("scsi_miss",  32'h4100_0000, 1'b0, 1'b1, 1, -1);

    configured     = 1'b0;
    bus_if.CFGIN_n = 1'b1;
    run_cycle("cfgin_hi",   32'hFF00_0000, 1'b1, 1'b0, 1, -1);
    bus_if.CFGIN_n = 1'b0;
    shutup         = 1'b1;
    run_cycle("shutup",     32'hFF00_0000, 1'b1, 1'b0, 1, -1);
    shutup         = 1'b0;

    configured = 1'b1;
    run_cycle("scsi_tmo",   32'h4000_0010, 1'b0, 1'b0, -1, -1);
    run_cycle("wrong_ack",  32'h4000_0020, 1'b1, 1'b0, 1, -1);
    run_cycle("host_abort", 32'h4000_0030, 1'b0, 1'b0, -1, 1);

    // Reset while the bus is acknowledged: outputs must drop without waiting for a clock
    configured = 1'b0;
    @(negedge CLK);
    bus_if.A     = 30'(32'hFF00_0044 >> 2);
    bus_if.FCS_n = 1'b0;
    bus_if.DS_n  = 4'h0;
    n = 0;
    while (bus_if.DTACK_n && n < 20) begin
      @(negedge CLK);
      n++;
      if (autoconfig_cycle) ac_dtack = 1'b1;
    end
    chk("rst_mid.dtack_low", 32'(bus_if.DTACK_n), 32'd0);
    chk("rst_mid.addrl",     32'(ADDRL),          32'h11);
    #2 RESET_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_addrl = 7'd0;
    release_bus();
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) @(negedge CLK);
    run_cycle("ac_after_rst", 32'hFF00_0044, 1'b1, 1'b0, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
